// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM state
// encodings, immediate / PC / write-back select codes and instruction classes.
// Optional build macro: ILLEGAL_TRAP_EN adds the TRAP state.
package multicycle_ctrl_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate generator output select
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // Next-PC select
    localparam logic [1:0] PCSEL_PC4 = 2'd0;
    localparam logic [1:0] PCSEL_IMM = 2'd1;
    localparam logic [1:0] PCSEL_ALU = 2'd2;

    // Register-file write-back select
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
`ifdef ILLEGAL_TRAP_EN
        StHalt   = 3'd5,
        StTrap   = 3'd6
`else
        StHalt   = 3'd5
`endif
    } state_e;

    // Coarse instruction class used by the sequencer
    typedef enum logic [3:0] {
        ClsAlu,
        ClsBranch,
        ClsLoad,
        ClsStore,
        ClsJal,
        ClsJalr,
        ClsLui,
        ClsSystem,
        ClsIllegal
    } ins_class_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and the
// shared datapath plus memory ports (slave).
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        br_taken;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic        rf_we;
    logic [1:0]  wb_sel;

    modport master (
        input  instr, br_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
               alu_a_pc, alu_b_imm, rf_we, wb_sel
    );

    modport slave (
        output instr, br_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
               alu_a_pc, alu_b_imm, rf_we, wb_sel
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decoder: immediate select, ALU operand muxes,
// write-back select and instruction class for the sequencer.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    output logic [2:0]  o_imm_sel,
    output logic        o_alu_a_pc,
    output logic        o_alu_b_imm,
    output logic [1:0]  o_wb_sel,
    output ins_class_e  o_cls
);

    // Opcode to datapath steering; anything unrecognised is ClsIllegal
    always_comb begin
        o_imm_sel   = IMM_I;
        o_alu_a_pc  = 1'b0;
        o_alu_b_imm = 1'b0;
        o_wb_sel    = WB_ALU;
        o_cls       = ClsIllegal;
        case (i_opcode)
            OPC_LOAD: begin
                o_alu_b_imm = 1'b1;
                o_wb_sel    = WB_LOAD;
                o_cls       = ClsLoad;
            end
            OPC_STORE: begin
                o_imm_sel   = IMM_S;
                o_alu_b_imm = 1'b1;
                o_cls       = ClsStore;
            end
            OPC_BRANCH: begin
                o_imm_sel  = IMM_B;
                o_alu_a_pc = 1'b1;
                o_cls      = ClsBranch;
            end
            OPC_JAL: begin
                o_imm_sel  = IMM_J;
                o_alu_a_pc = 1'b1;
                o_wb_sel   = WB_PC4;
                o_cls      = ClsJal;
            end
            OPC_JALR: begin
                o_alu_b_imm = 1'b1;
                o_wb_sel    = WB_PC4;
                o_cls       = ClsJalr;
            end
            OPC_OP:     o_cls = ClsAlu;
            OPC_OP_IMM: begin
                o_alu_b_imm = 1'b1;
                o_cls       = ClsAlu;
            end
            OPC_LUI: begin
                o_imm_sel = IMM_U;
                o_wb_sel  = WB_IMM;
                o_cls     = ClsLui;
            end
            OPC_AUIPC: begin
                o_imm_sel  = IMM_U;
                o_alu_a_pc = 1'b1;
                o_cls      = ClsAlu;
            end
            // Only ECALL/EBREAK (funct3=0) are recognised; CSR forms are not RV32I
            OPC_SYSTEM: if (i_funct3 == 3'b000) o_cls = ClsSystem;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait
// timeout and a retired-instruction counter.
// Optional build macro: ILLEGAL_TRAP_EN traps unknown opcodes into TRAP and adds
// the sticky o_illegal flag; without it unknown opcodes retire as NOPs.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    multicycle_ctrl_if.master  bus,
    output logic               o_timeout,
`ifdef ILLEGAL_TRAP_EN
    output logic               o_illegal,
`endif
    output logic [CNT_W-1:0]   o_instret,
    output logic [2:0]         o_state
);

    localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e             r_state, w_state_d;
    logic [WaitW-1:0]   r_wait_cnt, w_wait_cnt_d;
    logic [CNT_W-1:0]   r_instret;
    logic               r_timeout;
    logic               w_retire, w_timeout_set, w_wait_last;
    logic [2:0]         w_imm_sel;
    logic               w_alu_a_pc, w_alu_b_imm;
    logic [1:0]         w_wb_sel;
    ins_class_e         w_cls;
`ifdef ILLEGAL_TRAP_EN
    logic               r_illegal;
    logic               w_illegal_set;
`endif

    multicycle_ctrl_decode u_decode (
        .i_opcode    (bus.instr[6:0]),
        .i_funct3    (bus.instr[14:12]),
        .o_imm_sel   (w_imm_sel),
        .o_alu_a_pc  (w_alu_a_pc),
        .o_alu_b_imm (w_alu_b_imm),
        .o_wb_sel    (w_wb_sel),
        .o_cls       (w_cls)
    );

    // Last permitted wait cycle in FETCH/MEM; an ack here still wins
    assign w_wait_last = (r_wait_cnt == WaitW'(WAIT_MAX - 1));

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= StFetch;
        else          r_state <= w_state_d;
    end

    // Next-state logic plus retire/timeout/illegal events
    always_comb begin
        w_state_d     = r_state;
        w_retire      = 1'b0;
        w_timeout_set = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal_set = 1'b0;
`endif
        case (r_state)
            StFetch: begin
                if (bus.imem_ack) begin
                    w_state_d = StDecode;
                end else if (w_wait_last) begin
                    w_state_d     = StHalt;
                    w_timeout_set = 1'b1;
                end
            end
            StDecode: begin
                if (w_cls == ClsSystem) begin
                    w_state_d = StHalt;
                    w_retire  = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                end else if (w_cls == ClsIllegal) begin
                    w_state_d     = StTrap;
                    w_illegal_set = 1'b1;
`endif
                end else begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (w_cls == ClsBranch) begin
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                end else if (w_cls == ClsLoad || w_cls == ClsStore) begin
                    w_state_d = StMem;
                end else begin
                    w_state_d = StWb;
                end
            end
            StMem: begin
                if (bus.dmem_ack) begin
                    if (w_cls == ClsStore) begin
                        w_state_d = StFetch;
                        w_retire  = 1'b1;
                    end else begin
                        w_state_d = StWb;
                    end
                end else if (w_wait_last) begin
                    w_state_d     = StHalt;
                    w_timeout_set = 1'b1;
                end
            end
            StWb: begin
                w_state_d = StFetch;
                w_retire  = 1'b1;
            end
            default: w_state_d = r_state;
        endcase
    end

    // Wait counter restarts whenever a waiting state is entered or left
    always_comb begin
        w_wait_cnt_d = '0;
        if ((r_state == StFetch || r_state == StMem) && w_state_d == r_state) begin
            w_wait_cnt_d = r_wait_cnt + WaitW'(1);
        end
    end

    // Counters and sticky status flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
            r_instret  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
            if (w_retire)      r_instret <= r_instret + CNT_W'(1);
            if (w_timeout_set) r_timeout <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky illegal-instruction flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)          r_illegal <= 1'b0;
        else if (w_illegal_set) r_illegal <= 1'b1;
    end

    assign o_illegal = r_illegal;
`endif

    // Moore/decode outputs; everything held low while reset is asserted
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.ir_we     = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_sel    = PCSEL_PC4;
        bus.imm_sel   = IMM_I;
        bus.alu_a_pc  = 1'b0;
        bus.alu_b_imm = 1'b0;
        bus.rf_we     = 1'b0;
        bus.wb_sel    = WB_ALU;
        if (i_rst_n) begin
            case (r_state)
                StFetch: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ack;
                end
                StDecode: bus.imm_sel = w_imm_sel;
                StExec: begin
                    bus.imm_sel   = w_imm_sel;
                    bus.alu_a_pc  = w_alu_a_pc;
                    bus.alu_b_imm = w_alu_b_imm;
                    if (w_cls == ClsBranch) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = bus.br_taken ? PCSEL_IMM : PCSEL_PC4;
                    end
                end
                StMem: begin
                    bus.imm_sel  = w_imm_sel;
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = (w_cls == ClsStore);
                    bus.pc_we    = bus.dmem_ack && (w_cls == ClsStore);
                end
                StWb: begin
                    bus.imm_sel = w_imm_sel;
                    bus.wb_sel  = w_wb_sel;
                    // Unknown opcodes reach here as NOPs and must not write
                    bus.rf_we   = (bus.instr[11:7] != 5'd0) && (w_cls != ClsIllegal);
                    bus.pc_we   = 1'b1;
                    if (w_cls == ClsJal)       bus.pc_sel = PCSEL_IMM;
                    else if (w_cls == ClsJalr) bus.pc_sel = PCSEL_ALU;
                end
                default: ;
            endcase
        end
    end

    assign o_timeout = r_timeout;
    assign o_instret = r_instret;
    assign o_state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default WAIT_MAX=15).
// Compile with ILLEGAL_TRAP_EN defined to exercise the TRAP variant.
module tb_multicycle_ctrl;

    localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_BEQ  = 32'h0000_0463; // beq x0,x0,8
    localparam logic [31:0] I_LW   = 32'h0000_A103; // lw x2,0(x1)
    localparam logic [31:0] I_SW   = 32'h0020_A023; // sw x2,0(x1)
    localparam logic [31:0] I_JAL  = 32'h0000_00EF; // jal x1,0
    localparam logic [31:0] I_LUI0 = 32'h0000_1037; // lui x0,1
    localparam logic [31:0] I_ECAL = 32'h0000_0073; // ecall
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        timeout;
    logic [31:0] instret;
    logic [2:0]  state;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl_if u_if ();

    multicycle_ctrl #(
        .CNT_W    (32),
        .WAIT_MAX (15)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (u_if),
        .o_timeout (timeout),
`ifdef ILLEGAL_TRAP_EN
        .o_illegal (illegal),
`endif
        .o_instret (instret),
        .o_state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed after this and outputs checked 1ns later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // FETCH with same-cycle ack, leaves the DUT in DECODE
    task automatic fetch(input logic [31:0] ins);
        u_if.instr    = ins;
        u_if.imem_ack = 1'b1;
        #1;
        check("fetch state", state, 0);
        check("fetch imem_req", u_if.imem_req, 1);
        check("fetch ir_we", u_if.ir_we, 1);
        tick();
        u_if.imem_ack = 1'b0;
        #1;
        check("decode state", state, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        #1;
        check("rst state", state, 0);
        check("rst instret", instret, 0);
        check("rst timeout", timeout, 0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int req_cnt;
        int we_cnt;

        rst_n         = 1'b0;
        u_if.instr    = 32'h0;
        u_if.br_taken = 1'b0;
        u_if.imem_ack = 1'b0;
        u_if.dmem_ack = 1'b0;
        tick();
        tick();
        #1;
        check("rst state", state, 0);
        check("rst instret", instret, 0);
        check("rst timeout", timeout, 0);
        check("rst imem_req", u_if.imem_req, 0);
        check("rst pc_we", u_if.pc_we, 0);
        check("rst imm_sel", u_if.imm_sel, 0);
        rst_n = 1'b1;
        #1;
        check("post-rst imem_req", u_if.imem_req, 1);

        // ADDI: 0,1,2,4
        fetch(I_ADDI);
        check("addi imm_sel", u_if.imm_sel, 0);
        check("addi decode rf_we", u_if.rf_we, 0);
        tick(); #1;
        check("addi exec state", state, 2);
        check("addi alu_b_imm", u_if.alu_b_imm, 1);
        check("addi alu_a_pc", u_if.alu_a_pc, 0);
        check("addi exec pc_we", u_if.pc_we, 0);
        tick(); #1;
        check("addi wb state", state, 4);
        check("addi rf_we", u_if.rf_we, 1);
        check("addi wb_sel", u_if.wb_sel, 0);
        check("addi pc_we", u_if.pc_we, 1);
        check("addi pc_sel", u_if.pc_sel, 0);
        tick(); #1;
        check("addi done state", state, 0);
        check("addi instret", instret, 1);
        check("addi rf_we low", u_if.rf_we, 0);

        // BEQ taken: 0,1,2
        u_if.br_taken = 1'b1;
        fetch(I_BEQ);
        check("beq imm_sel", u_if.imm_sel, 2);
        tick(); #1;
        check("beq exec state", state, 2);
        check("beq pc_we", u_if.pc_we, 1);
        check("beq pc_sel", u_if.pc_sel, 1);
        check("beq rf_we", u_if.rf_we, 0);
        check("beq alu_a_pc", u_if.alu_a_pc, 1);
        tick(); #1;
        u_if.br_taken = 1'b0;
        check("beq done state", state, 0);
        check("beq instret", instret, 2);

        // LW with 2 fetch wait cycles and dmem_ack on the 4th MEM cycle
        u_if.instr = I_LW;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("fwait imem_req", u_if.imem_req, 1);
            check("fwait ir_we", u_if.ir_we, 0);
            tick();
        end
        fetch(I_LW);
        check("lw imm_sel", u_if.imm_sel, 0);
        tick(); #1;
        check("lw exec alu_b_imm", u_if.alu_b_imm, 1);
        tick();
        req_cnt = 0;
        we_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) u_if.dmem_ack = 1'b1;
            #1;
            if (u_if.dmem_req === 1'b1 && state == 3'd3) req_cnt++;
            if (u_if.dmem_we === 1'b1) we_cnt++;
            tick();
        end
        u_if.dmem_ack = 1'b0;
        #1;
        check("lw dmem_req cycles", req_cnt, 4);
        check("lw dmem_we cycles", we_cnt, 0);
        check("lw wb state", state, 4);
        check("lw wb_sel", u_if.wb_sel, 1);
        check("lw rf_we", u_if.rf_we, 1);
        tick(); #1;
        check("lw instret", instret, 3);

        // JAL x1
        fetch(I_JAL);
        check("jal imm_sel", u_if.imm_sel, 3);
        tick(); #1;
        check("jal alu_a_pc", u_if.alu_a_pc, 1);
        tick(); #1;
        check("jal wb state", state, 4);
        check("jal pc_sel", u_if.pc_sel, 1);
        check("jal wb_sel", u_if.wb_sel, 2);
        check("jal rf_we", u_if.rf_we, 1);
        tick(); #1;
        check("jal instret", instret, 4);

        // LUI with rd=x0: no register write
        fetch(I_LUI0);
        check("lui imm_sel", u_if.imm_sel, 4);
        tick(); tick(); #1;
        check("lui wb state", state, 4);
        check("lui rd0 rf_we", u_if.rf_we, 0);
        check("lui wb_sel", u_if.wb_sel, 3);
        check("lui pc_we", u_if.pc_we, 1);
        tick(); #1;
        check("lui instret", instret, 5);

        // Unknown opcode
        fetch(I_BAD);
        tick(); #1;
`ifdef ILLEGAL_TRAP_EN
        check("bad trap state", state, 6);
        check("bad illegal", illegal, 1);
        tick(); tick(); #1;
        check("bad trap hold", state, 6);
        check("bad pc_we", u_if.pc_we, 0);
        check("bad instret", instret, 5);
`else
        check("bad exec state", state, 2);
        tick(); #1;
        check("bad wb state", state, 4);
        check("bad rf_we", u_if.rf_we, 0);
        check("bad pc_we", u_if.pc_we, 1);
        check("bad pc_sel", u_if.pc_sel, 0);
        tick(); #1;
        check("bad instret", instret, 6);
`endif

        // Reset during MEM of a load: aborted, nothing retires
        do_reset();
        fetch(I_LW);
        tick(); tick(); #1;
        check("abort mem state", state, 3);
        rst_n = 1'b0;
        #1;
        check("abort rf_we", u_if.rf_we, 0);
        tick(); #1;
        rst_n = 1'b1;
        #1;
        check("abort state", state, 0);
        check("abort instret", instret, 0);
        check("abort rf_we after", u_if.rf_we, 0);

        // ECALL -> HALT from DECODE, retires
        fetch(I_ECAL);
        tick(); #1;
        check("ecall state", state, 5);
        check("ecall instret", instret, 1);
        check("ecall imem_req", u_if.imem_req, 0);
        tick(); #1;
        check("ecall hold", state, 5);

        // SW with ack on the 15th MEM cycle: ack wins
        do_reset();
        fetch(I_SW);
        check("sw imm_sel", u_if.imm_sel, 1);
        tick(); #1;
        check("sw alu_b_imm", u_if.alu_b_imm, 1);
        tick();
        req_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) u_if.dmem_ack = 1'b1;
            #1;
            if (u_if.dmem_req === 1'b1 && u_if.dmem_we === 1'b1) req_cnt++;
            if (i == 14) begin
                check("sw ack pc_we", u_if.pc_we, 1);
                check("sw ack pc_sel", u_if.pc_sel, 0);
            end
            tick();
        end
        u_if.dmem_ack = 1'b0;
        #1;
        check("sw15 req cycles", req_cnt, 15);
        check("sw15 state", state, 0);
        check("sw15 timeout", timeout, 0);
        check("sw15 instret", instret, 1);

        // SW without ack -> timeout after 15 MEM cycles
        fetch(I_SW);
        tick(); tick(); #1;
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (state != 3'd3) break;
            if (u_if.dmem_req === 1'b1 && u_if.dmem_we === 1'b1) req_cnt++;
            check("sw to no early timeout", timeout, 0);
            tick(); #1;
        end
        check("sw to req cycles", req_cnt, 15);
        check("sw to state", state, 5);
        check("sw to timeout", timeout, 1);
        check("sw to dmem_req", u_if.dmem_req, 0);
        u_if.dmem_ack = 1'b1;
        tick(); tick(); #1;
        u_if.dmem_ack = 1'b0;
        check("halt hold state", state, 5);
        check("halt pc_we", u_if.pc_we, 0);
        check("halt imem_req", u_if.imem_req, 0);
        check("halt instret", instret, 1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
